// File: rtl/param_sat_updown_counter_if.sv
// param_sat_updown_counter_if: control, bound and status bundle for the saturating up/down counter.
// UDC_OVF_COUNT_EN adds the ovf_cnt status field.
interface param_sat_updown_counter_if #(parameter int WIDTH = 8);
  logic en, up, dn, mode, ld, clr_flags;
  logic signed [WIDTH-1:0] step, lo, hi, ld_val, q;
  logic at_max, at_min, ovf_pulse, sticky_ovf, cfg_err;
`ifdef UDC_OVF_COUNT_EN
  logic [15:0] ovf_cnt;
`endif
  modport master(
    output en, up, dn, mode, ld, clr_flags, step, lo, hi, ld_val,
    input q, at_max, at_min, ovf_pulse, sticky_ovf, cfg_err
`ifdef UDC_OVF_COUNT_EN
    , ovf_cnt
`endif
  );
  modport slave(
    input en, up, dn, mode, ld, clr_flags, step, lo, hi, ld_val,
    output q, at_max, at_min, ovf_pulse, sticky_ovf, cfg_err
`ifdef UDC_OVF_COUNT_EN
    , ovf_cnt
`endif
  );
endinterface

// File: rtl/param_sat_updown_counter.sv
// param_sat_updown_counter: signed up/down counter with programmable step, [lo,hi] bounds, saturate/wrap.
// UDC_OVF_COUNT_EN adds a saturating 16-bit overflow event counter.
module param_sat_updown_counter #(
  parameter int WIDTH = 8,
  parameter int RST_VAL = 0
) (
  input logic clk,
  input logic rst,
  param_sat_updown_counter_if.slave bus
);
  localparam int W2 = WIDTH + 2;
  logic rdy, bad, op, upd, ovf, over, under, wrap;
  logic signed [W2-1:0] qx, sx, lx, hx, ldx, nx, vx, rx;
  logic signed [WIDTH-1:0] q_nxt;
  always_comb begin
    qx = {{2{bus.q[WIDTH-1]}}, bus.q};
    sx = {{2{bus.step[WIDTH-1]}}, bus.step};
    lx = {{2{bus.lo[WIDTH-1]}}, bus.lo};
    hx = {{2{bus.hi[WIDTH-1]}}, bus.hi};
    ldx = {{2{bus.ld_val[WIDTH-1]}}, bus.ld_val};
    bad = lx > hx;
    op = bus.en & (bus.up ^ bus.dn);
    nx = bus.up ? qx + sx : qx - sx;
    vx = bus.ld ? ldx : nx;
    over = vx > hx;
    under = vx < lx;
    wrap = bus.mode & ~bus.ld;
    rx = over ? (wrap ? lx : hx) : under ? (wrap ? hx : lx) : vx;
    upd = ~bad & (bus.ld | op);
    ovf = ~bad & ~bus.ld & op & (over | under);
    q_nxt = upd ? WIDTH'(rx) : bus.q;
  end
  // rdy delays the first update to the second edge after reset release
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rdy <= 1'b0;
      bus.q <= WIDTH'(RST_VAL);
      bus.at_max <= 1'b0;
      bus.at_min <= 1'b0;
      bus.ovf_pulse <= 1'b0;
      bus.sticky_ovf <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else if (!rdy) begin
      rdy <= 1'b1;
    end else begin
      bus.q <= q_nxt;
      bus.at_max <= q_nxt == bus.hi;
      bus.at_min <= q_nxt == bus.lo;
      bus.ovf_pulse <= ovf;
      bus.sticky_ovf <= (bus.sticky_ovf & ~bus.clr_flags) | ovf;
      bus.cfg_err <= bad;
    end
`ifdef UDC_OVF_COUNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) bus.ovf_cnt <= '0;
    else if (rdy) bus.ovf_cnt <= bus.clr_flags ? 16'(ovf) : (&bus.ovf_cnt) ? bus.ovf_cnt : bus.ovf_cnt + 16'(ovf);
`endif
endmodule

// File: tb/tb_param_sat_updown_counter.sv
// tb_param_sat_updown_counter: random and directed checks against an integer model of the counter.
module tb_param_sat_updown_counter;
  localparam int W = 8;
  localparam int RV = 0;
  logic clk = 1'b0, rst = 1'b0;
  int checks = 0, errors = 0;
  bit cmp_on = 1'b0;
  int mq, msync, mcnt;
  bit mmax, mmin, mov, msticky, merr;
  param_sat_updown_counter_if #(.WIDTH(W)) bus();
  param_sat_updown_counter #(.WIDTH(W), .RST_VAL(RV)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq = RV; msync = 0; mcnt = 0;
    mmax = 0; mmin = 0; mov = 0; msticky = 0; merr = 0;
  endtask

  task automatic model_step();
    int l, h, nx;
    if (msync == 0) begin msync = 1; return; end
    l = int'(bus.lo); h = int'(bus.hi);
    mov = 0;
    merr = l > h;
    if (!merr) begin
      if (bus.ld) begin
        nx = int'(bus.ld_val);
        mq = nx < l ? l : nx > h ? h : nx;
      end else if (bus.en && (bus.up != bus.dn)) begin
        nx = bus.up ? mq + int'(bus.step) : mq - int'(bus.step);
        if (nx > h) begin mq = bus.mode ? l : h; mov = 1; end
        else if (nx < l) begin mq = bus.mode ? h : l; mov = 1; end
        else mq = nx;
      end
    end
    mmax = mq == h; mmin = mq == l;
    msticky = (msticky && !bus.clr_flags) || mov;
    mcnt = bus.clr_flags ? int'(mov) : (mcnt == 65535 ? mcnt : mcnt + int'(mov));
  endtask

  always @(negedge clk) if (cmp_on) begin
    chk("q", int'(bus.q), mq);
    chk("at_max", int'(bus.at_max), int'(mmax));
    chk("at_min", int'(bus.at_min), int'(mmin));
    chk("ovf_pulse", int'(bus.ovf_pulse), int'(mov));
    chk("sticky_ovf", int'(bus.sticky_ovf), int'(msticky));
    chk("cfg_err", int'(bus.cfg_err), int'(merr));
`ifdef UDC_OVF_COUNT_EN
    chk("ovf_cnt", int'(bus.ovf_cnt), mcnt);
`endif
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en = 0; bus.up = 0; bus.dn = 0; bus.ld = 0; bus.clr_flags = 0;
  endtask

  task automatic count(input bit u, input bit d, input int s);
    idle(); bus.en = 1; bus.up = u; bus.dn = d; bus.step = W'(s);
    tick();
  endtask

  task automatic load(input int v);
    idle(); bus.ld = 1; bus.ld_val = W'(v);
    tick();
  endtask

  initial begin
    idle(); bus.mode = 0; bus.step = 0; bus.ld_val = 0; bus.lo = -128; bus.hi = 127;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_q", int'(bus.q), RV);
    chk("rst_at_max", int'(bus.at_max), 0);
    chk("rst_sticky", int'(bus.sticky_ovf), 0);
    chk("rst_cfg_err", int'(bus.cfg_err), 0);
    rst = 1; cmp_on = 1;
    count(1, 0, 5);
    chk("sync_hold", int'(bus.q), RV);
    count(1, 0, 5);
    chk("first_update", int'(bus.q), RV + 5);
    load(120);
    count(1, 0, 10);
    chk("t1_q", int'(bus.q), 127);
    chk("t1_ovf", int'(bus.ovf_pulse), 1);
    chk("t1_sticky", int'(bus.sticky_ovf), 1);
    count(1, 0, 10);
    chk("t1_rep_q", int'(bus.q), 127);
    chk("t1_rep_ovf", int'(bus.ovf_pulse), 1);
    bus.mode = 1; bus.lo = -10; bus.hi = 10;
    load(8);
    count(1, 0, 5);
    chk("t2_wrap_lo", int'(bus.q), -10);
    chk("t2_ovf", int'(bus.ovf_pulse), 1);
    count(0, 1, 3);
    chk("t2_wrap_hi", int'(bus.q), 10);
    count(1, 1, 3);
    chk("t3_hold_q", int'(bus.q), 10);
    chk("t3_hold_ovf", int'(bus.ovf_pulse), 0);
    bus.hi = 20;
    load(50);
    chk("t3_ld_clamp", int'(bus.q), 20);
    chk("t3_at_max", int'(bus.at_max), 1);
    bus.lo = 5; bus.hi = -5;
    count(1, 0, 1);
    chk("t4_cfg_err", int'(bus.cfg_err), 1);
    chk("t4_q_held", int'(bus.q), 20);
    load(0);
    chk("t4_ld_ignored", int'(bus.q), 20);
    bus.lo = -10; bus.hi = 20;
    count(1, 0, -1);
    chk("t4_resume", int'(bus.q), 19);
    chk("t4_cfg_clr", int'(bus.cfg_err), 0);
    count(1, 0, 0);
    #2 rst = 0; cmp_on = 0;
    #1;
    chk("t5_async_q", int'(bus.q), RV);
    chk("t5_async_sticky", int'(bus.sticky_ovf), 0);
    model_reset();
    @(negedge clk);
    #1 rst = 1; cmp_on = 1;
`ifdef UDC_OVF_COUNT_EN
    bus.mode = 0; bus.lo = -10; bus.hi = 10;
    tick();
    load(10);
    repeat (3) count(1, 0, 1);
    chk("t6_cnt3", int'(bus.ovf_cnt), 3);
    idle(); bus.clr_flags = 1; tick();
    chk("t6_cnt_clr", int'(bus.ovf_cnt), 0);
    idle(); bus.clr_flags = 1; bus.en = 1; bus.up = 1; tick();
    chk("t6_cnt_clr_ovf", int'(bus.ovf_cnt), 1);
`endif
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        int a, b;
        a = $urandom_range(255) - 128; b = $urandom_range(255) - 128;
        if ($urandom_range(9) != 0 && a > b) begin int t; t = a; a = b; b = t; end
        bus.lo = W'(a); bus.hi = W'(b); bus.mode = 1'($urandom);
      end
      bus.en = $urandom_range(9) < 8;
      bus.up = 1'($urandom); bus.dn = 1'($urandom);
      bus.step = W'($urandom_range(40) - 20);
      bus.ld = $urandom_range(19) == 0;
      bus.ld_val = W'($urandom);
      bus.clr_flags = $urandom_range(19) == 0;
      tick();
    end
    cmp_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
